// File: rtl/key_conditioner_if.sv
// Push-button bundle between the raw DE2-115 keys and the adder's register control.
interface key_conditioner_if #(
    parameter int unsigned NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] Key_n;
    logic [NUM_KEYS-1:0] Pressed;
    logic [NUM_KEYS-1:0] Press_pulse;
    logic [NUM_KEYS-1:0] Release_pulse;

    modport master (
        output Key_n,
        input  Pressed,
        input  Press_pulse,
        input  Release_pulse
    );

    modport slave (
        input  Key_n,
        output Pressed,
        output Press_pulse,
        output Release_pulse
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key 2-flop synchronizer plus counter debouncer for active-low push-buttons;
// produces a clean held level and single-cycle press/release pulses.
module key_conditioner #(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic               Clk,
    input  logic               Reset,
    key_conditioner_if.slave   keys
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronized samples are kept active-high; 0 means released.
    logic [NUM_KEYS-1:0]            s1_q;
    logic [NUM_KEYS-1:0]            s2_q;
    logic [NUM_KEYS-1:0]            pressed_q;
    logic [NUM_KEYS-1:0]            pressed_d;
    logic [NUM_KEYS-1:0]            press_q;
    logic [NUM_KEYS-1:0]            press_d;
    logic [NUM_KEYS-1:0]            release_q;
    logic [NUM_KEYS-1:0]            release_d;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_d;

    // State registers: synchronizer, debounce counters, level and pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            pressed_q <= '0;
            press_q   <= '0;
            release_q <= '0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= ~keys.Key_n;
            s2_q      <= s1_q;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (s2_q[i] == pressed_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]     = '0;
                pressed_d[i] = s2_q[i];
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign keys.Pressed       = pressed_q;
    assign keys.Press_pulse   = press_q;
    assign keys.Release_pulse = release_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever any pulse is presented.
module tb_key_conditioner;
    localparam int unsigned NK  = 3;
    localparam int unsigned DEB = 4;
    localparam int          LAT = 6;   // posedges from drive to visible pulse, DEB+2

    typedef struct {
        int       cyc;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] level;
    } exp_t;

    logic Clk;
    logic Reset;
    int   cyc;
    int   checks;
    int   failures;
    bit   mon_en;
    exp_t exp_q[$];

    key_conditioner_if #(.NUM_KEYS(NK)) keys ();

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .keys  (keys.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [2:0] p, input logic [2:0] r, input logic [2:0] lvl);
        exp_t e;
        e.cyc   = cyc + LAT;
        e.press = p;
        e.rel   = r;
        e.level = lvl;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (mon_en && ((keys.Press_pulse | keys.Release_pulse) !== 3'b000)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {26'd0, keys.Press_pulse, keys.Release_pulse}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("press_pulse", 32'(keys.Press_pulse), 32'(e.press));
                    chk("release_pulse", 32'(keys.Release_pulse), 32'(e.rel));
                    chk("pressed_level", 32'(keys.Pressed), 32'(e.level));
                end
            end
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        mon_en     = 1'b0;
        Reset      = 1'b1;
        keys.Key_n = 3'b111;

        // 1: reset then idle, nothing should move
        tick(1);
        mon_en = 1'b1;
        chk("reset_pressed", 32'(keys.Pressed), 32'd0);
        tick(2);
        Reset = 1'b0;
        tick(20);
        chk("idle_pressed", 32'(keys.Pressed), 32'd0);

        // 2: clean press on key 1
        keys.Key_n[1] = 1'b0;
        push(3'b010, 3'b000, 3'b010);
        tick(LAT - 1);
        chk("k1_not_yet", 32'(keys.Pressed), 32'd0);
        tick(1);
        chk("k1_pressed", 32'(keys.Pressed), 32'h2);
        tick(6);

        // 3: bouncing press on key 0
        keys.Key_n[0] = 1'b0; tick(3);
        keys.Key_n[0] = 1'b1; tick(1);
        keys.Key_n[0] = 1'b0; tick(2);
        keys.Key_n[0] = 1'b1; tick(1);
        chk("k0_no_early_flip", 32'(keys.Pressed), 32'h2);
        keys.Key_n[0] = 1'b0;
        push(3'b001, 3'b000, 3'b011);
        tick(10);

        // 4: short glitch on key 2, then release key 1
        keys.Key_n[2] = 1'b0; tick(3);
        keys.Key_n[2] = 1'b1; tick(10);
        chk("k2_glitch_ignored", 32'(keys.Pressed), 32'h3);
        keys.Key_n[1] = 1'b1;
        push(3'b000, 3'b010, 3'b001);
        tick(10);

        // 5: release key 0, then keys 0 and 2 together
        keys.Key_n[0] = 1'b1;
        push(3'b000, 3'b001, 3'b000);
        tick(10);
        keys.Key_n = 3'b010;
        push(3'b101, 3'b000, 3'b101);
        tick(10);
        keys.Key_n = 3'b111;
        push(3'b000, 3'b101, 3'b000);
        tick(10);

        // 6: reset in the middle of a debounce on key 1, key kept low
        keys.Key_n[1] = 1'b0;
        tick(4);
        Reset = 1'b1;
        tick(1);
        chk("mid_reset_pressed", 32'(keys.Pressed), 32'd0);
        Reset = 1'b0;
        push(3'b010, 3'b000, 3'b010);
        tick(LAT - 1);
        chk("post_reset_not_yet", 32'(keys.Pressed), 32'd0);
        tick(5);
        keys.Key_n[1] = 1'b1;
        push(3'b000, 3'b010, 3'b000);
        tick(10);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_pressed", 32'(keys.Pressed), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
